// File: rtl/pavana_resp_reorder_if.sv
// Bus bundle for the response reorder buffer: issue side, slave response side and
// the ordered valid/ready output with status.
interface pavana_resp_reorder_if #(
   parameter int unsigned TAG_WIDTH  = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_LOG  = 2
);
   logic                  issue_i;
   logic [TAG_WIDTH-1:0]  issue_tag_i;
   logic                  issue_full_o;
   logic                  resp_i;
   logic [TAG_WIDTH-1:0]  resp_tag_i;
   logic [DATA_WIDTH-1:0] resp_data_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [TAG_WIDTH-1:0]  out_tag_o;
   logic [DATA_WIDTH-1:0] out_data_o;
   logic [DEPTH_LOG:0]    pending_o;
   logic                  err_o;

   modport slave (
      input  issue_i, issue_tag_i, resp_i, resp_tag_i, resp_data_i, out_ready_i,
      output issue_full_o, out_valid_o, out_tag_o, out_data_o, pending_o, err_o
   );

   modport master (
      output issue_i, issue_tag_i, resp_i, resp_tag_i, resp_data_i, out_ready_i,
      input  issue_full_o, out_valid_o, out_tag_o, out_data_o, pending_o, err_o
   );
endinterface

// File: rtl/pavana_resp_reorder.sv
// Response reorder buffer: records issue order of read tags, buffers out-of-order
// responses and releases them in issue order through a registered valid/ready stage.
module pavana_resp_reorder #(
   parameter int unsigned TAG_WIDTH  = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_LOG  = 2,
   parameter int unsigned BYPASS_EN  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   pavana_resp_reorder_if.slave bus
);
   localparam int unsigned NTAG  = 1 << TAG_WIDTH;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG;
   localparam int unsigned PW    = DEPTH_LOG + 1;

   logic [TAG_WIDTH-1:0]  fifo_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_q  [NTAG];
   logic [DEPTH_LOG-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PW-1:0]         pending_q;
   logic [NTAG-1:0]       outstanding_q, outstanding_d;
   logic [NTAG-1:0]       stored_q, stored_d;
   logic                  out_valid_q;
   logic [TAG_WIDTH-1:0]  out_tag_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  err_q;

   logic                  full, empty, slot, bypass_hit, rel, use_bypass;
   logic                  issue_ok, resp_ok, err_set;
   logic [TAG_WIDTH-1:0]  head;

   // Accept/release decisions; full is taken from the pre-pop count
   always_comb begin
      full          = (pending_q == PW'(DEPTH));
      empty         = (pending_q == '0);
      head          = fifo_q[rd_ptr_q];
      resp_ok       = bus.resp_i & outstanding_q[bus.resp_tag_i] & ~stored_q[bus.resp_tag_i];
      bypass_hit    = (BYPASS_EN != 0) & resp_ok & (bus.resp_tag_i == head);
      slot          = ~out_valid_q | bus.out_ready_i;
      rel           = ~empty & slot & (stored_q[head] | bypass_hit);
      use_bypass    = rel & ~stored_q[head];
      // a tag being released this cycle may be reissued in the same cycle
      issue_ok      = bus.issue_i & ~full &
                      (~outstanding_q[bus.issue_tag_i] | (rel & (bus.issue_tag_i == head)));
      err_set       = (bus.issue_i & ~issue_ok) | (bus.resp_i & ~resp_ok);
      outstanding_d = outstanding_q;
      stored_d      = stored_q;
      if (rel) begin
         outstanding_d[head] = 1'b0;
         stored_d[head]      = 1'b0;
      end
      if (resp_ok & ~use_bypass) stored_d[bus.resp_tag_i] = 1'b1;
      if (issue_ok) outstanding_d[bus.issue_tag_i] = 1'b1;
   end

   // Control state and registered output stage
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         pending_q     <= '0;
         outstanding_q <= '0;
         stored_q      <= '0;
         out_valid_q   <= 1'b0;
         out_tag_q     <= '0;
         out_data_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         stored_q      <= stored_d;
         pending_q     <= pending_q + PW'(issue_ok) - PW'(rel);
         err_q         <= err_q | err_set;
         if (issue_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
         if (rel) begin
            rd_ptr_q    <= rd_ptr_q + DEPTH_LOG'(1);
            out_valid_q <= 1'b1;
            out_tag_q   <= head;
            out_data_q  <= use_bypass ? bus.resp_data_i : mem_q[head];
         end else if (slot) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Storage arrays carry no reset; validity lives in the bitmaps and pointers
   always_ff @(posedge clk_i) begin
      if (issue_ok) fifo_q[wr_ptr_q] <= bus.issue_tag_i;
      if (resp_ok) mem_q[bus.resp_tag_i] <= bus.resp_data_i;
   end

   assign bus.issue_full_o = full;
   assign bus.out_valid_o  = out_valid_q;
   assign bus.out_tag_o    = out_tag_q;
   assign bus.out_data_o   = out_data_q;
   assign bus.pending_o    = pending_q;
   assign bus.err_o        = err_q;
endmodule

// File: tb/tb_pavana_resp_reorder.sv
// Bench for pavana_resp_reorder: directed scenarios plus random traffic on a bypass
// instance checked against a queue model; a non-bypass instance checks 2-cycle latency.
module tb_pavana_resp_reorder;
   localparam int unsigned TW = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned DL = 2;
   localparam int NT = 4;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   pavana_resp_reorder_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH_LOG(DL)) b0 ();
   pavana_resp_reorder_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH_LOG(DL)) b1 ();

   pavana_resp_reorder #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH_LOG(DL), .BYPASS_EN(0))
      dut0 (.clk_i(clk), .rst_i(rst_n), .bus(b0.slave));
   pavana_resp_reorder #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH_LOG(DL), .BYPASS_EN(1))
      dut1 (.clk_i(clk), .rst_i(rst_n), .bus(b1.slave));

   // Reference model: issue-order queue plus per-tag outstanding/arrived flags
   int          oq[$];
   bit          m_out  [NT];
   bit          m_have [NT];
   logic [31:0] m_mem  [NT];
   bit          m_ov;
   logic [1:0]  m_ot;
   logic [31:0] m_od;
   bit          m_err;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      oq.delete();
      for (int i = 0; i < NT; i++) begin
         m_out[i]  = 1'b0;
         m_have[i] = 1'b0;
      end
      m_ov = 1'b0; m_ot = '0; m_od = '0; m_err = 1'b0;
   endtask

   task automatic model_step();
      bit slot, ne, good_resp, rel, good_iss;
      int head, rt, it;
      rt        = int'(b1.resp_tag_i);
      it        = int'(b1.issue_tag_i);
      ne        = (oq.size() > 0);
      head      = ne ? oq[0] : 0;
      slot      = !m_ov || b1.out_ready_i;
      good_resp = b1.resp_i && m_out[rt] && !m_have[rt];
      rel       = slot && ne && (m_have[head] || (good_resp && rt == head));
      good_iss  = b1.issue_i && (oq.size() < DP) && (!m_out[it] || (rel && it == head));
      if ((b1.issue_i && !good_iss) || (b1.resp_i && !good_resp)) m_err = 1'b1;
      if (rel) begin
         m_ov = 1'b1;
         m_ot = 2'(head);
         m_od = m_have[head] ? m_mem[head] : b1.resp_data_i;
         void'(oq.pop_front());
         m_out[head]  = 1'b0;
         m_have[head] = 1'b0;
      end else if (slot) begin
         m_ov = 1'b0;
      end
      if (good_resp && !(rel && rt == head)) begin
         m_mem[rt]  = b1.resp_data_i;
         m_have[rt] = 1'b1;
      end
      if (good_iss) begin
         oq.push_back(it);
         m_out[it] = 1'b1;
      end
   endtask

   task automatic compare();
      chk("out_valid", 64'(b1.out_valid_o), 64'(m_ov));
      if (m_ov) begin
         chk("out_tag", 64'(b1.out_tag_o), 64'(m_ot));
         chk("out_data", 64'(b1.out_data_o), 64'(m_od));
      end
      chk("pending", 64'(b1.pending_o), 64'(oq.size()));
      chk("err", 64'(b1.err_o), 64'(m_err));
      chk("issue_full", 64'(b1.issue_full_o), 64'(oq.size() == DP));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic set_in(input bit iss, input int itag, input bit rsp, input int rtag,
                         input logic [31:0] d, input bit rdy);
      b1.issue_i = iss; b1.issue_tag_i = 2'(itag);
      b1.resp_i = rsp;  b1.resp_tag_i = 2'(rtag); b1.resp_data_i = d;
      b1.out_ready_i = rdy;
      b0.issue_i = iss; b0.issue_tag_i = 2'(itag);
      b0.resp_i = rsp;  b0.resp_tag_i = 2'(rtag); b0.resp_data_i = d;
      b0.out_ready_i = rdy;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, '0, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(b1.out_valid_o), 64'(0));
      chk("rst_tag", 64'(b1.out_tag_o), 64'(0));
      chk("rst_data", 64'(b1.out_data_o), 64'(0));
      chk("rst_pending", 64'(b1.pending_o), 64'(0));
      chk("rst_err", 64'(b1.err_o), 64'(0));
      chk("rst_full", 64'(b1.issue_full_o), 64'(0));
      chk("rst_valid0", 64'(b0.out_valid_o), 64'(0));
      chk("rst_pending0", 64'(b0.pending_o), 64'(0));
      model_clear();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic rand_cycle();
      int  free_t[$];
      int  cand[$];
      bit  iss, rsp, rdy;
      int  itag, rtag;
      for (int t = 0; t < NT; t++) begin
         if (!m_out[t]) free_t.push_back(t);
         if (m_out[t] && !m_have[t]) cand.push_back(t);
      end
      iss  = ($urandom_range(0, 1) == 1);
      if (oq.size() == DP && $urandom_range(0, 99) != 0) iss = 1'b0;
      itag = int'($urandom_range(0, NT - 1));
      if (free_t.size() > 0 && $urandom_range(0, 99) != 0)
         itag = free_t[$urandom_range(0, free_t.size() - 1)];
      rsp  = ($urandom_range(0, 2) != 0);
      rtag = int'($urandom_range(0, NT - 1));
      if (cand.size() > 0 && $urandom_range(0, 99) != 0)
         rtag = cand[$urandom_range(0, cand.size() - 1)];
      else if (cand.size() == 0 && $urandom_range(0, 99) != 0)
         rsp = 1'b0;
      rdy = ($urandom_range(0, 3) != 0);
      set_in(iss, itag, rsp, rtag, $urandom, rdy);
      tick();
   endtask

   initial begin
      do_reset();

      // 1: in order, both instances; bypass=0 lags one extra cycle
      for (int k = 0; k < 4; k++) begin set_in(1, k, 0, 0, '0, 1); tick(); end
      chk("s1_pending4", 64'(b1.pending_o), 64'(4));
      for (int k = 0; k < 6; k++) begin
         if (k < 4) set_in(0, 0, 1, k, 32'hA000_0000 + 32'(k), 1);
         else       set_in(0, 0, 0, 0, '0, 1);
         tick();
         if (k < 4) begin
            chk("s1_byp_tag", 64'(b1.out_tag_o), 64'(k));
            chk("s1_byp_data", 64'(b1.out_data_o), 64'(32'hA000_0000 + 32'(k)));
         end
         if (k == 0 || k == 5) begin
            chk("s1_nobyp_valid", 64'(b0.out_valid_o), 64'(0));
         end else begin
            chk("s1_nobyp_valid", 64'(b0.out_valid_o), 64'(1));
            chk("s1_nobyp_tag", 64'(b0.out_tag_o), 64'(k - 1));
            chk("s1_nobyp_data", 64'(b0.out_data_o), 64'(32'hA000_0000 + 32'(k - 1)));
         end
      end
      chk("s1_pending0", 64'(b0.pending_o), 64'(0));
      chk("s1_err", 64'(b0.err_o), 64'(0));

      // 2: reverse responses
      for (int k = 0; k < 4; k++) begin set_in(1, k, 0, 0, '0, 1); tick(); end
      for (int k = 3; k >= 0; k--) begin
         set_in(0, 0, 1, k, 32'hB000_0000 + 32'(k), 1);
         tick();
         chk("s2_valid", 64'(b1.out_valid_o), 64'(k == 0));
      end
      for (int k = 1; k < 4; k++) begin
         set_in(0, 0, 0, 0, '0, 1);
         tick();
         chk("s2_tag", 64'(b1.out_tag_o), 64'(k));
      end
      set_in(0, 0, 0, 0, '0, 1); tick();

      // 3: backpressure
      set_in(1, 0, 0, 0, '0, 0); tick();
      set_in(1, 1, 0, 0, '0, 0); tick();
      set_in(0, 0, 1, 0, 32'hC0, 0); tick();
      set_in(0, 0, 1, 1, 32'hC1, 0); tick();
      for (int k = 0; k < 5; k++) begin
         set_in(0, 0, 0, 0, '0, 0);
         tick();
         chk("s3_hold_tag", 64'(b1.out_tag_o), 64'(0));
         chk("s3_hold_data", 64'(b1.out_data_o), 64'(32'hC0));
         chk("s3_hold_pend", 64'(b1.pending_o), 64'(1));
      end
      set_in(0, 0, 0, 0, '0, 1); tick();
      chk("s3_next_tag", 64'(b1.out_tag_o), 64'(1));
      tick();

      // 4: full
      for (int k = 0; k < 4; k++) begin set_in(1, k, 0, 0, '0, 0); tick(); end
      chk("s4_full", 64'(b1.issue_full_o), 64'(1));
      set_in(1, 2, 0, 0, '0, 0); tick();
      chk("s4_pend", 64'(b1.pending_o), 64'(4));
      chk("s4_err", 64'(b1.err_o), 64'(1));
      for (int k = 0; k < 4; k++) begin set_in(0, 0, 1, k, 32'hD0 + 32'(k), 1); tick(); end
      set_in(0, 0, 0, 0, '0, 1); tick();

      // 5: unknown tag, then a duplicate response
      do_reset();
      set_in(0, 0, 1, 2, 32'hE2, 1); tick();
      chk("s5_unknown_err", 64'(b1.err_o), 64'(1));
      do_reset();
      set_in(1, 1, 0, 0, '0, 1); tick();
      set_in(1, 2, 0, 0, '0, 1); tick();
      set_in(0, 0, 1, 2, 32'hF2, 1); tick();
      chk("s5_no_err_yet", 64'(b1.err_o), 64'(0));
      set_in(0, 0, 1, 2, 32'hBAD, 1); tick();
      chk("s5_dup_err", 64'(b1.err_o), 64'(1));
      set_in(0, 0, 1, 1, 32'hF1, 1); tick();
      chk("s5_out1", 64'(b1.out_data_o), 64'(32'hF1));
      set_in(0, 0, 0, 0, '0, 1); tick();
      chk("s5_out2", 64'(b1.out_data_o), 64'(32'hF2));

      // 6: reset mid-flight
      do_reset();
      for (int k = 0; k < 4; k++) begin set_in(1, k, 0, 0, '0, 0); tick(); end
      set_in(0, 0, 1, 0, 32'h60, 0); tick();
      chk("s6_pend3", 64'(b1.pending_o), 64'(3));
      do_reset();
      set_in(1, 0, 0, 0, '0, 1); tick();
      chk("s6_reissue", 64'(b1.pending_o), 64'(1));
      set_in(0, 0, 1, 0, 32'h61, 1); tick();
      set_in(0, 0, 0, 0, '0, 1); tick();

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) rand_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
